spi_upcounter_dp: RTL and testbench

- Datapath stage directly downstream of the up-counter control unit.
- Consumes the registered level signals runstop and clear, and runs a decimal up-counter from 0 to COUNT_MAX.
- Each time the count value changes, it serialises the value as two bytes into the SPI master's byte handshake.
- Also exports the live count for local display.

---
 rtl/spi_upcounter_pkg.sv | 17 +
 rtl/spi_upcounter_dp_if.sv | 25 ++
 rtl/spi_upcounter_tick_gen.sv | 41 ++++
 rtl/spi_upcounter_dp.sv | 127 ++++++++++++
 tb/tb_spi_upcounter_dp.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_upcounter_pkg.sv
// Shared types and defaults for the up-counter datapath and its SPI byte handshake.
package spi_upcounter_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned COUNT_W_DEFAULT   = 14;
  localparam int unsigned COUNT_MAX_DEFAULT = 9999;

  // Two-byte frame transmitter states
  typedef enum logic [2:0] {
    StIdle,
    StSendHi,
    StWaitHi,
    StSendLo,
    StWaitLo
  } tx_state_t;

endpackage

// File: rtl/spi_upcounter_dp_if.sv
// Byte handshake between the counter datapath (master) and the SPI byte engine (slave).
interface spi_upcounter_dp_if
  import spi_upcounter_pkg::*;
();

  logic              start;
  logic [BYTE_W-1:0] tx_data;
  logic              ready;
  logic              done;

  modport master (
    output start,
    output tx_data,
    input  ready,
    input  done
  );

  modport slave (
    input  start,
    input  tx_data,
    output ready,
    output done
  );

endinterface

// File: rtl/spi_upcounter_tick_gen.sv
// Prescaler: divides clk by TICK_DIV while enabled, emitting a one-cycle tick on the last count.
module spi_upcounter_tick_gen #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);

  logic [PresW-1:0] presc_q, presc_d;
  logic             at_last;

  assign at_last = (presc_q == PresLast);
  // Tick is not masked by clear; the counter gives clear priority itself.
  assign o_tick  = i_en && at_last;

  // Next prescaler value: clear to zero, advance while enabled, otherwise hold
  always_comb begin
    presc_d = presc_q;
    if (i_clr) begin
      presc_d = '0;
    end else if (i_en) begin
      presc_d = at_last ? '0 : presc_q + PresW'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/spi_upcounter_dp.sv
// Decimal up-counter that ships every new count value to the SPI master as a two-byte frame.
module spi_upcounter_dp
  import spi_upcounter_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned COUNT_MAX = COUNT_MAX_DEFAULT,
  parameter int unsigned COUNT_W   = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_runstop,
  input  logic               i_clear,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_tick,
  output logic               o_busy,
  spi_upcounter_dp_if.master bus
);

  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] snap_q, snap_d;
  logic               pending_q, pending_d;
  logic               pend_clr;
  logic               tick;
  tx_state_t          state_q, state_d;
  logic [15:0]        snap_ext;
  logic [BYTE_W-1:0]  byte_hi, byte_lo;

  spi_upcounter_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (i_runstop),
    .i_clr  (i_clear),
    .o_tick (tick)
  );

  assign o_tick  = tick;
  assign o_count = count_q;
  assign o_busy  = (state_q != StIdle);

  // Frame bytes come from the snapshot so a count change mid-frame cannot tear it.
  assign snap_ext = 16'(snap_q);
  assign byte_hi  = snap_ext[15:8];
  assign byte_lo  = snap_ext[7:0];

  // Next count: clear wins over tick, tick wraps at COUNT_MAX
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = (count_q == COUNT_W'(COUNT_MAX)) ? '0 : count_q + COUNT_W'(1);
    end
  end

  // Pending flag: a change in the same cycle the frame latches still re-arms it
  always_comb begin
    pending_d = pending_q;
    if (count_d != count_q) begin
      pending_d = 1'b1;
    end else if (pend_clr) begin
      pending_d = 1'b0;
    end
  end

  // Tx FSM next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    pend_clr    = 1'b0;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          snap_d   = count_q;
          pend_clr = 1'b1;
          state_d  = StSendHi;
        end
      end
      StSendHi: begin
        bus.tx_data = byte_hi;
        if (bus.ready) begin
          bus.start = 1'b1;
          state_d   = StWaitHi;
        end
      end
      StWaitHi: begin
        bus.tx_data = byte_hi;
        if (bus.done) begin
          state_d = StSendLo;
        end
      end
      StSendLo: begin
        bus.tx_data = byte_lo;
        if (bus.ready) begin
          bus.start = 1'b1;
          state_d   = StWaitLo;
        end
      end
      StWaitLo: begin
        bus.tx_data = byte_lo;
        if (bus.done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      state_q   <= StIdle;
    end else begin
      count_q   <= count_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_spi_upcounter_dp.sv
// Directed bench for spi_upcounter_dp with a simple SPI byte-engine model.
module tb_spi_upcounter_dp;
  import spi_upcounter_pkg::*;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned CountW  = COUNT_W_DEFAULT;

  logic              clk = 1'b0;
  logic              reset;
  logic              runstop;
  logic              clear;
  logic [CountW-1:0] count;
  logic              tick;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // SPI master model state
  logic ready_en;
  logic spi_busy_q;
  int   spi_cnt_q;
  logic done_q;

  // Byte monitor
  logic [7:0] rx_q[$];
  logic       start_prev;
  logic       double_start  = 1'b0;
  logic       start_blocked = 1'b0;

  always #5 clk = ~clk;

  spi_upcounter_dp_if bus ();

  assign bus.ready = ready_en && !spi_busy_q;
  assign bus.done  = done_q;

  spi_upcounter_dp #(
    .TICK_DIV  (TickDiv),
    .COUNT_MAX (COUNT_MAX_DEFAULT),
    .COUNT_W   (CountW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_runstop (runstop),
    .i_clear   (clear),
    .o_count   (count),
    .o_tick    (tick),
    .o_busy    (busy),
    .bus       (bus)
  );

  // SPI model: done pulses 8 cycles after a start, ready low meanwhile
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_busy_q <= 1'b0;
      spi_cnt_q  <= 0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        spi_busy_q <= 1'b1;
        spi_cnt_q  <= 8;
      end else if (spi_busy_q) begin
        if (spi_cnt_q == 1) begin
          done_q     <= 1'b1;
          spi_busy_q <= 1'b0;
        end
        spi_cnt_q <= spi_cnt_q - 1;
      end
    end
  end

  // Capture every transmitted byte and flag illegal start behaviour
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b0;
    end else begin
      if (bus.start) rx_q.push_back(bus.tx_data);
      if (bus.start && start_prev) double_start <= 1'b1;
      if (bus.start && !ready_en) start_blocked <= 1'b1;
      start_prev <= bus.start;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare captured bytes (first byte in the most significant position) then flush
  task automatic expect_rx(input string tag, input int exp_n, input logic [31:0] exp_bytes);
    logic [7:0] exp_b;
    check_eq({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (i < rx_q.size()) begin
        exp_b = exp_bytes[8*(exp_n-1-i) +: 8];
        check_eq($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_b));
      end
    end
    rx_q.delete();
  endtask

  initial begin
    logic [9:0] tick_vec;
    logic       tick_seen;
    int         guard;

    reset    = 1'b1;
    runstop  = 1'b0;
    clear    = 1'b0;
    ready_en = 1'b1;
    cycles(3);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_tick", 32'(tick), 0);
    check_eq("rst_start", 32'(bus.start), 0);
    check_eq("rst_txdata", 32'(bus.tx_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    cycles(5);
    expect_rx("rst_noframe", 0, 0);

    // Run 10 cycles: ticks on the 4th and 8th prescaler cycles
    runstop = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      tick_vec[k-1] = tick;
      if (k == 4) check_eq("run_count1", 32'(count), 1);
    end
    runstop = 1'b0;
    check_eq("run_tick_pattern", 32'(tick_vec), 32'b0001000100);
    check_eq("run_count2", 32'(count), 2);
    cycles(80);
    expect_rx("run_frames", 4, 32'h0000_0002 | 32'h0001_0000);

    // Run up to 9998, then two ticks across the wrap
    runstop = 1'b1;
    guard = 0;
    while (count != CountW'(9998) && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    runstop = 1'b0;
    check_eq("reach_9998", 32'(count), 9998);
    cycles(80);
    rx_q.delete();
    runstop = 1'b1;
    cycles(4);
    check_eq("wrap_9999", 32'(count), 9999);
    cycles(4);
    check_eq("wrap_0", 32'(count), 0);
    runstop = 1'b0;
    cycles(80);
    expect_rx("wrap_frames", 4, 32'h270F_0000);

    // Pause mid-prescale: prescaler at 2 when runstop drops
    runstop = 1'b1;
    cycles(2);
    runstop = 1'b0;
    tick_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tick_seen |= tick;
    end
    check_eq("pause_no_tick", 32'(tick_seen), 0);
    check_eq("pause_count", 32'(count), 0);
    check_eq("pause_no_frame", 32'(rx_q.size()), 0);
    runstop = 1'b1;
    check_eq("resume_tick_early", 32'(tick), 0);
    cycles(1);
    check_eq("resume_tick", 32'(tick), 1);
    cycles(1);
    check_eq("resume_count", 32'(count), 1);
    runstop = 1'b0;
    cycles(40);
    expect_rx("resume_frame", 2, 32'h0001);

    // Clear coinciding with a tick at count 5
    runstop = 1'b1;
    cycles(16);
    runstop = 1'b0;
    check_eq("pre_clear_count", 32'(count), 5);
    cycles(80);
    rx_q.delete();
    runstop = 1'b1;
    cycles(3);
    check_eq("clear_tick_coincide", 32'(tick), 1);
    clear = 1'b1;
    cycles(1);
    check_eq("clear_count", 32'(count), 0);
    clear   = 1'b0;
    runstop = 1'b0;
    cycles(40);
    expect_rx("clear_frame", 2, 32'h0000);
    clear = 1'b1;
    cycles(3);
    clear = 1'b0;
    cycles(40);
    expect_rx("clear_at_zero", 0, 0);
    check_eq("clear_at_zero_busy", 32'(busy), 0);

    // Back-pressure: five ticks while ready is held low
    ready_en = 1'b0;
    runstop  = 1'b1;
    cycles(20);
    runstop = 1'b0;
    cycles(10);
    check_eq("bp_no_start", 32'(rx_q.size()), 0);
    check_eq("bp_busy", 32'(busy), 1);
    check_eq("bp_count", 32'(count), 5);
    ready_en = 1'b1;
    cycles(60);
    expect_rx("bp_frames", 4, 32'h0001_0005);

    // Reset while waiting for the high byte to finish
    runstop = 1'b1;
    cycles(4);
    runstop = 1'b0;
    check_eq("pre_rst_count", 32'(count), 6);
    guard = 0;
    while (!bus.start && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("pre_rst_start_seen", 32'(bus.start), 1);
    cycles(1);
    check_eq("pre_rst_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_start", 32'(bus.start), 0);
    check_eq("midrst_count", 32'(count), 0);
    @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    cycles(40);
    check_eq("postrst_no_frame", 32'(rx_q.size()), 0);
    check_eq("postrst_busy", 32'(busy), 0);
    runstop = 1'b1;
    cycles(4);
    runstop = 1'b0;
    check_eq("postrst_count", 32'(count), 1);
    cycles(40);
    expect_rx("postrst_frame", 2, 32'h0001);

    check_eq("start_one_cycle", 32'(double_start), 0);
    check_eq("start_while_not_ready", 32'(start_blocked), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
